// File: rtl/urv_divide_iter.sv
// urv_divide_iter: iterative RV32M DIV/DIVU/REM/REMU unit for the uRV execute stage.
// Retires BITS_PER_CYCLE quotient bits per cycle with restoring division on operand magnitudes.
// Optional build macro: URV_DIV_EARLY_OUT_EN (zero divisor / signed overflow skip the iterations).
module urv_divide_iter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    input  logic            d_valid_i,
    input  logic            d_is_divide_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic            x_stall_req_o,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_busy_o
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e             state_q;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN:0]      rem_q;
    logic [XLEN-1:0]    quo_q;
    logic [XLEN-1:0]    div_q;
    logic [XLEN-1:0]    rs1_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               sel_rem_q;
    logic               dz_q;
    logic               ovf_q;
    logic [XLEN-1:0]    rd_q;
    logic               busy_q;

    // Operand decode, valid only while the instruction is presented in PREP
    logic               signed_op_c;
    logic               s1_c;
    logic               s2_c;
    logic [XLEN-1:0]    mag1_c;
    logic [XLEN-1:0]    mag2_c;
    logic               dz_c;
    logic               ovf_c;
    logic               fun_unused_c;

    assign signed_op_c  = ~d_fun_i[0];
    assign s1_c         = signed_op_c & d_rs1_i[XLEN-1];
    assign s2_c         = signed_op_c & d_rs2_i[XLEN-1];
    assign mag1_c       = s1_c ? (XLEN'(0) - d_rs1_i) : d_rs1_i;
    assign mag2_c       = s2_c ? (XLEN'(0) - d_rs2_i) : d_rs2_i;
    assign dz_c         = (d_rs2_i == '0);
    assign ovf_c        = signed_op_c & (d_rs1_i == INT_MIN) & (d_rs2_i == '1);
    assign fun_unused_c = d_fun_i[2];

    // One iteration: BITS_PER_CYCLE restoring shift/subtract steps
    logic [XLEN:0]      rem_nxt;
    logic [XLEN-1:0]    quo_nxt;

    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            rem_nxt = {rem_nxt[XLEN-1:0], quo_nxt[XLEN-1]};
            quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            if (rem_nxt >= {1'b0, div_q}) begin
                rem_nxt    = rem_nxt - {1'b0, div_q};
                quo_nxt[0] = 1'b1;
            end
        end
    end

    // Sign correction then special-case overrides, evaluated in FIX
    logic [XLEN-1:0]    q_fix_c;
    logic [XLEN-1:0]    r_fix_c;
    logic [XLEN-1:0]    result_c;

    always_comb begin
        q_fix_c = neg_q_q ? (XLEN'(0) - quo_q) : quo_q;
        r_fix_c = neg_r_q ? (XLEN'(0) - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        if (dz_q) begin
            q_fix_c = '1;
            r_fix_c = rs1_q;
        end else if (ovf_q) begin
            q_fix_c = INT_MIN;
            r_fix_c = '0;
        end
        result_c = sel_rem_q ? r_fix_c : q_fix_c;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; kill overrides every transition
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (d_valid_i && d_is_divide_i && !x_kill_i) begin
                    state_nxt = PREP;
                end
            end
            PREP: begin
`ifdef URV_DIV_EARLY_OUT_EN
                if (dz_c || ovf_c) begin
                    state_nxt = FIX;
                end else begin
                    state_nxt = ITER;
                end
`else
                state_nxt = ITER;
`endif
            end
            ITER: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (!x_stall_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (x_kill_i) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: operand latch in PREP, iteration in ITER, result capture in FIX
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            rs1_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            case (state_q)
                PREP: begin
                    cnt_q     <= '0;
                    rem_q     <= '0;
                    quo_q     <= mag1_c;
                    div_q     <= mag2_c;
                    rs1_q     <= d_rs1_i;
                    neg_q_q   <= s1_c ^ s2_c;
                    neg_r_q   <= s1_c;
                    sel_rem_q <= d_fun_i[1];
                    dz_q      <= dz_c;
                    ovf_q     <= ovf_c;
                end
                ITER: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                end
                FIX: begin
                    if (!x_kill_i) begin
                        rd_q <= result_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Busy flag tracks the state the FSM is entering
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
        end
    end

    assign x_stall_req_o = d_valid_i & d_is_divide_i & ~x_kill_i & (state_q != DONE);
    assign x_rd_o        = rd_q;
    assign x_busy_o      = busy_q;

endmodule

// File: tb/tb_urv_divide_iter.sv
// tb_urv_divide_iter: directed vectors for the iterative divider (BPC=1 and BPC=4 instances).
module tb_urv_divide_iter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        x_stall_i = 1'b0;
    logic        x_kill_i = 1'b0;
    logic        v1 = 1'b0;
    logic        v4 = 1'b0;
    logic        is_div = 1'b1;
    logic [2:0]  fun = 3'b101;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        sr1, sr4, busy1, busy4;
    logic [31:0] rd1, rd4;

    int checks = 0;
    int errors = 0;

`ifdef URV_DIV_EARLY_OUT_EN
    localparam int SPECIAL_STALL = 3;
`else
    localparam int SPECIAL_STALL = 35;
`endif

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    always #5 clk_i = ~clk_i;

    urv_divide_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_div1 (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .d_valid_i(v1), .d_is_divide_i(is_div), .d_fun_i(fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2),
        .x_stall_req_o(sr1), .x_rd_o(rd1), .x_busy_o(busy1)
    );

    urv_divide_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u_div4 (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .d_valid_i(v4), .d_is_divide_i(is_div), .d_fun_i(fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2),
        .x_stall_req_o(sr4), .x_rd_o(rd4), .x_busy_o(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one divide, count stall-request cycles, check the result in DONE,
    // optionally hold x_stall_i in DONE for 'hold' cycles with the instruction still presented.
    task automatic run(input bit sel, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_rd,
                       input int exp_stall, input int hold, input string tag);
        int  n = 0;
        bit  done = 0;
        @(negedge clk_i);
        fun = f; rs1 = a; rs2 = b;
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (sel ? sr4 : sr1) begin
                n++;
                @(negedge clk_i);
            end else begin
                done = 1;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_rd"}, sel ? rd4 : rd1, exp_rd);
        if (hold > 0) begin
            x_stall_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                check({tag, "_hold_rd"}, sel ? rd4 : rd1, exp_rd);
                check({tag, "_hold_req"}, 32'(sel ? sr4 : sr1), 32'd0);
                check({tag, "_hold_busy"}, 32'(sel ? busy4 : busy1), 32'd1);
            end
            x_stall_i = 1'b0;
        end
        if (sel) v4 = 1'b0; else v1 = 1'b0;
        @(negedge clk_i);
        check({tag, "_idle"}, 32'(sel ? busy4 : busy1), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_rd1", rd1, 32'h0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_req1", 32'(sr1), 32'd0);
        check("rst_rd4", rd4, 32'h0);
        rst_i = 1'b1;

        run(0, F_DIVU, 32'd100, 32'd7, 32'd14, 35, 0, "divu_100_7");
        run(0, F_REMU, 32'd100, 32'd7, 32'd2, 35, 0, "remu_100_7");
        run(0, F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 0, "div_m7_2");
        run(0, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 0, "rem_m7_2");
        run(0, F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0, "div_7_m2");
        run(0, F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 35, 0, "rem_7_m2");
        run(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_STALL, 0, "div_ovf");
        run(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPECIAL_STALL, 0, "rem_ovf");
        run(0, F_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL, 0, "div_m5_0");
        run(0, F_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_STALL, 0, "rem_m5_0");
        run(0, F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL, 0, "divu_5_0");
        run(0, F_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_STALL, 0, "remu_5_0");

        // Kill in cycle 10 of a DIVU: request drops at once, unit idles, result untouched
        @(negedge clk_i);
        fun = F_DIVU; rs1 = 32'd1000; rs2 = 32'd3; v1 = 1'b1;
        repeat (10) @(negedge clk_i);
        check("kill_busy_before", 32'(busy1), 32'd1);
        x_kill_i = 1'b1;
        #1;
        check("kill_req", 32'(sr1), 32'd0);
        @(negedge clk_i);
        check("kill_busy", 32'(busy1), 32'd0);
        check("kill_rd", rd1, 32'd5);
        x_kill_i = 1'b0; v1 = 1'b0;

        run(0, F_DIVU, 32'd9, 32'd3, 32'd3, 35, 0, "divu_9_3");
        run(0, F_DIVU, 32'd0, 32'd1, 32'd0, 35, 0, "divu_0_1");

        // BPC=4 instance: 11-cycle stall and a 5-cycle external stall held in DONE
        run(1, F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 11, 5, "bpc4_divu");
        run(1, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 11, 0, "bpc4_rem");
        check("bpc1_rd_kept", rd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/urv_divide_iter.md
# urv_divide_iter

Iterative, parametrised RV32M divide/remainder unit for the uRV execute stage. It accepts DIV/DIVU/REM/REMU from decode, holds the pipeline through `x_stall_req_o` while it computes over multiple cycles, then presents the result on `x_rd_o` for the X/W register. This generalises the single-width divider hook: width and radix (bits retired per cycle) are configurable, and kill and external-stall handling are defined explicitly.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width. Must be even and ≥ 8.
- `BITS_PER_CYCLE`, default 1: quotient bits produced per iteration. Legal values are 1, 2 and 4; `XLEN % BITS_PER_CYCLE == 0`.

Ports:
- `clk_i` input, 1: clock.
- `rst_i` input, 1: reset, asynchronous, active-low.
- `x_stall_i` input, 1: pipeline stall from the hazard/stall controller.
- `x_kill_i` input, 1: flush of the instruction in X.
- `d_valid_i` input, 1: valid instruction in X.
- `d_is_divide_i` input, 1: instruction is DIV/DIVU/REM/REMU.
- `d_fun_i` input, 3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
- `d_rs1_i` input, XLEN: dividend.
- `d_rs2_i` input, XLEN: divisor.
- `x_stall_req_o` output, 1: divider needs the pipeline held.
- `x_rd_o` output, XLEN: quotient or remainder.
- `x_busy_o` output, 1: FSM not in IDLE (debug/perf).

## Operation
- Let N = XLEN/BITS_PER_CYCLE. Iterations use non-restoring-free restoring division on magnitudes. The remainder register is XLEN+1 bits; the quotient shifts in BITS_PER_CYCLE bits per cycle.
- FSM states are IDLE, PREP, ITER, FIX and DONE.
- **IDLE → PREP** when `d_valid_i & d_is_divide_i & !x_kill_i`.
- **PREP:** latch magnitudes and signs. Signed ops (DIV/REM) take the absolute value of both operands, and record `neg_q = s1 ^ s2` and `neg_r = s1`. Clear the iteration counter.
- **ITER:** N cycles; the counter runs 0..N-1; at N-1 go to FIX.
- **FIX:** apply sign correction (negate the quotient if `neg_q`, negate the remainder if `neg_r`). Then apply special-case overrides:
  - Divisor == 0: quotient is all-ones; remainder is the original `d_rs1_i`.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all-ones): quotient = rs1; remainder = 0.
  - Select quotient for fun[1]=0, remainder for fun[1]=1, and register the result into `x_rd_o`.
- **DONE:** the result is held on `x_rd_o`.
  - DONE → IDLE on the first cycle with `!x_stall_i`.
  - While `x_stall_i` is high, stay in DONE with `x_rd_o` stable. The instruction still presented in X must not restart the unit.
- **Kill:** `x_kill_i` in any state forces IDLE on the next edge. The partial result is discarded and `x_rd_o` is unchanged.
- **`x_stall_req_o` (combinational):**
  - `x_stall_req_o = d_valid_i & d_is_divide_i & !x_kill_i & (state != DONE)`.
  - It is therefore high from the accept cycle through FIX, and low in DONE.
- Operands are sampled only in PREP (from `d_rs1_i`/`d_rs2_i`, which are stable because X is stalled). Changes on the operands during ITER are ignored.
- `x_stall_i` does not freeze PREP/ITER/FIX; iteration proceeds regardless of external stall.

## Timing
- Reset values: state IDLE, `x_rd_o` = 0, counter 0, `x_stall_req_o` = 0, `x_busy_o` = 0.
- Cycle 0: instruction in X with `x_stall_req_o` = 1. Cycle 1: PREP. Cycles 2..N+1: ITER. Cycle N+2: FIX. Cycle N+3: DONE, `x_stall_req_o` = 0, `x_rd_o` valid, and the X/W register captures at the end of N+3.
- Stall-request duration is N+3 cycles: 35 for XLEN=32/BPC=1, 19 for BPC=2, 11 for BPC=4.
- Back-to-back divides: the next divide is accepted in the cycle after DONE exits (IDLE), so there is no lost cycle beyond IDLE re-entry.
- Reset asserted mid-operation: immediate return to reset values, asynchronously.

## Configuration
- `URV_DIV_EARLY_OUT_EN` defined:
  - In PREP, a zero divisor or the signed-overflow case jumps directly to FIX.
  - Total stall is 3 cycles: accept, PREP, FIX; DONE follows.
- `URV_DIV_EARLY_OUT_EN` undefined:
  - All divides take the full N+3 cycles.
  - Results are identical in both builds.

## Test plan
- DIVU 100/7 at XLEN=32, BPC=1 → `x_rd_o` = 14; `x_stall_req_o` high exactly 35 cycles. Repeating with REMU → 2.
- DIV -7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1). DIV 7/-2 → -3; REM → 1.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - With `URV_DIV_EARLY_OUT_EN`: stall 3 cycles.
  - Without it: stall 35 cycles.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Kill asserted in cycle 10 of a DIVU:
  - `x_stall_req_o` low in the same cycle, state IDLE next edge, `x_rd_o` unchanged.
  - A subsequent DIVU 9/3 returns 3.
- BPC=4 build, DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF with 11-cycle stall. Holding `x_stall_i` for 5 cycles in DONE keeps `x_rd_o` stable and does not restart the divide.
